// File: rtl/imm_instr_encoder_pkg.sv
// Shared definitions for the RISC-V immediate encoder/decoder pair:
// ImmSrc codes, instruction field positions and the field-packing helper.
package imm_instr_encoder_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_R = 2'b11
    } imm_src_e;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned INSTR_MSB  = 31;

    localparam int unsigned ERR_RANGE  = 0;
    localparam int unsigned ERR_ALIGN  = 1;

    typedef struct packed {
        imm_src_e    imm_src;
        logic [12:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
    } enc_fields_t;

    // Scatter the immediate bits into the format-specific slots; only the
    // low 13 immediate bits can ever reach the instruction word.
    function automatic logic [31:0] pack_instr(enc_fields_t f);
        logic [31:0] instr;
        instr = '0;
        instr[OPCODE_LSB +: 7] = f.opcode;
        instr[FUNCT3_LSB +: 3] = f.funct3;
        instr[RS1_LSB +: 5]    = f.rs1;
        case (f.imm_src)
            IMM_I: begin
                instr[RD_LSB +: 5]   = f.rd;
                instr[RS2_LSB +: 12] = f.imm[11:0];
            end
            IMM_S: begin
                instr[RD_LSB +: 5]      = f.imm[4:0];
                instr[RS2_LSB +: 5]     = f.rs2;
                instr[FUNCT7_LSB +: 7]  = f.imm[11:5];
            end
            IMM_B: begin
                instr[RD_LSB]             = f.imm[11];
                instr[(RD_LSB + 1) +: 4]  = f.imm[4:1];
                instr[RS2_LSB +: 5]       = f.rs2;
                instr[FUNCT7_LSB +: 6]    = f.imm[10:5];
                instr[INSTR_MSB]          = f.imm[12];
            end
            IMM_R: begin
                instr[RD_LSB +: 5]     = f.rd;
                instr[RS2_LSB +: 5]    = f.rs2;
                instr[FUNCT7_LSB +: 7] = f.funct7;
            end
            default: begin
                instr = '0;
            end
        endcase
        return instr;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational range/alignment check of a 32-bit immediate against the
// field width its ImmSrc format can encode.
module imm_range_check
    import imm_instr_encoder_pkg::*;
(
    input  logic [31:0] imm_i,
    input  imm_src_e    imm_src_i,
    output logic [1:0]  err_o
);

    // A value fits when every bit above the encodable sign bit matches it.
    always_comb begin
        err_o = 2'b00;
        case (imm_src_i)
            IMM_I, IMM_S: begin
                err_o[ERR_RANGE] = ~((&imm_i[31:11]) | ~(|imm_i[31:11]));
            end
            IMM_B: begin
                err_o[ERR_RANGE] = ~((&imm_i[31:12]) | ~(|imm_i[31:12]));
                err_o[ERR_ALIGN] = imm_i[0];
            end
            IMM_R: begin
                err_o = 2'b00;
            end
            default: begin
                err_o = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/imm_instr_encoder.sv
// Field-to-word RISC-V instruction encoder (I/S/B/R) with a two-stage
// valid/ready pipeline, range/alignment flags and delivery statistics.
module imm_instr_encoder
    import imm_instr_encoder_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_imm_src,
    input  logic [31:0]        in_imm,
    input  logic [6:0]         in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [2:0]         in_funct3,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [6:0]         in_funct7,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [1:0]         out_err,
    output logic [COUNT_W-1:0] enc_count,
    output logic [COUNT_W-1:0] err_count
);

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    logic               s1_valid_q, s1_valid_d;
    enc_fields_t        s1_fields_q, s1_fields_d;
    logic [1:0]         s1_err_q, s1_err_d;
    logic               s2_valid_q, s2_valid_d;
    logic [31:0]        s2_instr_q, s2_instr_d;
    logic [1:0]         s2_err_q, s2_err_d;
    logic [COUNT_W-1:0] enc_count_q, enc_count_d;
    logic [COUNT_W-1:0] err_count_q, err_count_d;

    logic [1:0]         range_err_s;
    logic               s1_advance_s;
    logic               in_ready_s;
    logic               in_accept_s;
    logic               out_hs_s;

    // S1 may hand over whenever S2 is empty or draining this cycle.
    assign s1_advance_s = !s2_valid_q || out_ready;
    assign in_ready_s   = !s1_valid_q || s1_advance_s;
    assign in_accept_s  = in_valid && in_ready_s;
    assign out_hs_s     = s2_valid_q && out_ready;

    imm_range_check u_range_check (
        .imm_i     (in_imm),
        .imm_src_i (imm_src_e'(in_imm_src)),
        .err_o     (range_err_s)
    );

    // Stage 1: capture the fields and the range flags of an accepted beat.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_fields_d = s1_fields_q;
        s1_err_d    = s1_err_q;
        if (in_accept_s) begin
            s1_valid_d          = 1'b1;
            s1_fields_d.imm_src = imm_src_e'(in_imm_src);
            s1_fields_d.imm     = in_imm[12:0];
            s1_fields_d.opcode  = in_opcode;
            s1_fields_d.rd      = in_rd;
            s1_fields_d.funct3  = in_funct3;
            s1_fields_d.rs1     = in_rs1;
            s1_fields_d.rs2     = in_rs2;
            s1_fields_d.funct7  = in_funct7;
            s1_err_d            = range_err_s;
        end else if (s1_advance_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2: pack the word; hold everything while the consumer stalls.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        if (s1_advance_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = pack_instr(s1_fields_q);
                s2_err_d   = s1_err_q;
            end else begin
                s2_instr_d = s2_instr_q;
                s2_err_d   = s2_err_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Delivery counters: enc_count wraps, err_count sticks at all-ones.
    always_comb begin
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (out_hs_s) begin
            enc_count_d = enc_count_q + CNT_ONE;
            if ((s2_err_q != 2'b00) && (err_count_q != CNT_MAX)) begin
                err_count_d = err_count_q + CNT_ONE;
            end else begin
                err_count_d = err_count_q;
            end
        end else begin
            enc_count_d = enc_count_q;
        end
    end

    // Pipeline and counter state; reset flushes both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_fields_q <= '0;
            s1_err_q    <= 2'b00;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= 32'h0000_0000;
            s2_err_q    <= 2'b00;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fields_q <= s1_fields_d;
            s1_err_q    <= s1_err_d;
            s2_valid_q  <= s2_valid_d;
            s2_instr_q  <= s2_instr_d;
            s2_err_q    <= s2_err_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_err   = s2_err_q;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Scoreboard bench for imm_instr_encoder: a reference packer and an
// independent decoder predict every delivered word.
module tb_imm_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_imm_src;
    logic [31:0] in_imm;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [6:0]  in_funct7;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_instr4;
    logic [1:0]  out_err4;
    logic [3:0]  enc_count4;
    logic [3:0]  err_count4;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  err;
        logic [1:0]  src;
        logic [31:0] imm;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    imm_instr_encoder #(.COUNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm_src(in_imm_src), .in_imm(in_imm), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct7(in_funct7), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    imm_instr_encoder #(.COUNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_imm_src(in_imm_src), .in_imm(in_imm), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct7(in_funct7), .out_valid(out_valid4), .out_ready(out_ready),
        .out_instr(out_instr4), .out_err(out_err4),
        .enc_count(enc_count4), .err_count(err_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] exp_word(logic [1:0] src, logic [31:0] imm, logic [6:0] op,
                                             logic [4:0] rd, logic [2:0] f3, logic [4:0] rs1,
                                             logic [4:0] rs2, logic [6:0] f7);
        case (src)
            2'b00:   return {imm[11:0], rs1, f3, rd, op};
            2'b01:   return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            2'b10:   return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            default: return {f7, rs2, rs1, f3, rd, op};
        endcase
    endfunction

    function automatic logic [1:0] exp_err(logic [1:0] src, logic [31:0] imm);
        int s;
        logic [1:0] e;
        s = $signed(imm);
        e = 2'b00;
        if (src == 2'b00 || src == 2'b01) begin
            if (s < -2048 || s > 2047) e[0] = 1'b1;
        end else if (src == 2'b10) begin
            if (s < -4096 || s > 4095) e[0] = 1'b1;
            if (imm[0]) e[1] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] dec_imm(logic [1:0] src, logic [31:0] w);
        case (src)
            2'b00:   return {{20{w[31]}}, w[31:20]};
            2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
            2'b10:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // One clock: record handshakes on both sides, then advance to the next negedge.
    task automatic tick(output bit acc);
        exp_t e;
        exp_t g;
        #1;
        acc = in_valid && in_ready && rst_n;
        if (acc) begin
            e.instr = exp_word(in_imm_src, in_imm, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7);
            e.err   = exp_err(in_imm_src, in_imm);
            e.src   = in_imm_src;
            e.imm   = in_imm;
            sb.push_back(e);
        end
        if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_extra: delivered instr=%h with nothing pending", out_instr);
            end else begin
                g = sb.pop_front();
                if (out_instr !== g.instr || out_err !== g.err) begin
                    failures++;
                    $display("FAIL sb_word: got instr=%h err=%b, expected instr=%h err=%b",
                             out_instr, out_err, g.instr, g.err);
                end
                if (g.err == 2'b00 && g.src != 2'b11) begin
                    checks++;
                    if (dec_imm(g.src, out_instr) !== g.imm) begin
                        failures++;
                        $display("FAIL round_trip: decoded imm=%h, expected %h (src=%b)",
                                 dec_imm(g.src, out_instr), g.imm, g.src);
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(logic [1:0] src, logic [31:0] imm, logic [6:0] op, logic [4:0] rd,
                         logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2, logic [6:0] f7);
        in_imm_src = src; in_imm = imm; in_opcode = op; in_rd = rd;
        in_funct3 = f3; in_rs1 = rs1; in_rs2 = rs2; in_funct7 = f7;
        in_valid = 1'b1;
    endtask

    task automatic send(logic [1:0] src, logic [31:0] imm, logic [6:0] op, logic [4:0] rd,
                        logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2, logic [6:0] f7);
        bit acc;
        acc = 1'b0;
        drive(src, imm, op, rd, f3, rs1, rs2, f7);
        for (int n = 0; n < 50; n++) begin
            tick(acc);
            if (acc) break;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout: accepted=%0d, expected 1 within 50 cycles", acc);
        end
    endtask

    task automatic wait_out(output bit ok);
        bit a;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick(a);
        end
    endtask

    task automatic drain();
        bit a;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 100 && sb.size() != 0; n++) tick(a);
        tick(a);
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_imm_src = 2'b00; in_imm = 32'h0; in_opcode = 7'h00; in_rd = 5'd0;
        in_funct3 = 3'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_funct7 = 7'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_instr, out_err, enc_count, err_count} !== {1'b0, 32'h0, 2'b00, 16'h0, 16'h0}) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b instr=%h err=%b enc=%0d errc=%0d, expected all 0",
                     out_valid, out_instr, out_err, enc_count, err_count);
        end
        checks++;
        if (in_ready !== 1'b1 || enc_count4 !== 4'h0 || err_count4 !== 4'h0) begin
            failures++;
            $display("FAIL reset_ready: in_ready=%b enc4=%0d err4=%0d, expected 1/0/0",
                     in_ready, enc_count4, err_count4);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_i_type();
        bit acc;
        out_ready = 1'b1;
        drive(2'b00, 32'hFFFF_FFFF, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'h00);
        tick(acc);
        in_valid = 1'b0;
        checks++;
        if (acc !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL i_latency1: accepted=%b out_valid=%b, expected 1/0", acc, out_valid);
        end
        tick(acc);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'hFFF1_0093 || out_err !== 2'b00) begin
            failures++;
            $display("FAIL i_word: valid=%b instr=%h err=%b, expected 1 fff10093 00",
                     out_valid, out_instr, out_err);
        end
        tick(acc);
    endtask

    task automatic test_s_b();
        bit ok;
        bit a;
        out_ready = 1'b1;
        send(2'b01, 32'd8, 7'h23, 5'd0, 3'd2, 5'd2, 5'd5, 7'h00);
        wait_out(ok);
        checks++;
        if (!ok || out_instr !== 32'h0051_2423 || dec_imm(2'b01, out_instr) !== 32'd8) begin
            failures++;
            $display("FAIL s_word: ok=%b instr=%h, expected 00512423 decoding to 8", ok, out_instr);
        end
        tick(a);
        send(2'b10, 32'hFFFF_FFFC, 7'h63, 5'd0, 3'd1, 5'd1, 5'd0, 7'h00);
        wait_out(ok);
        checks++;
        if (!ok || out_instr !== 32'hFE00_9EE3 || dec_imm(2'b10, out_instr) !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL b_word: ok=%b instr=%h, expected fe009ee3 decoding to -4", ok, out_instr);
        end
        tick(a);
    endtask

    task automatic test_errors();
        apply_reset();
        out_ready = 1'b1;
        send(2'b00, 32'd2048, 7'h13, 5'd3, 3'd0, 5'd4, 5'd0, 7'h00);
        send(2'b10, 32'd3,    7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00);
        send(2'b10, 32'd4096, 7'h63, 5'd0, 3'd5, 5'd6, 5'd7, 7'h00);
        drain();
        checks++;
        if (sb.size() != 0 || enc_count !== 16'd3 || err_count !== 16'd3) begin
            failures++;
            $display("FAIL err_counts: pending=%0d enc=%0d errc=%0d, expected 0/3/3",
                     sb.size(), enc_count, err_count);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        bit seen_low;
        bit prev_stall;
        logic [31:0] prev_instr;
        int sent;
        apply_reset();
        sent = 0; seen_low = 1'b0; prev_stall = 1'b0; prev_instr = 32'h0;
        for (int c = 0; c < 60; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            if (sent < 8)
                drive(2'(sent % 4), 32'(sent * 100 - 300), 7'h13 + 7'(sent), 5'(sent + 1),
                      3'(sent), 5'(sent + 8), 5'(31 - sent), 7'(sent * 3));
            else
                in_valid = 1'b0;
            #1;
            if (!in_ready) begin
                seen_low = 1'b1;
                checks++;
                if (sb.size() != 2) begin
                    failures++;
                    $display("FAIL ready_fall: in_ready=0 with %0d buffered, expected 2", sb.size());
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_instr !== prev_instr) begin
                    failures++;
                    $display("FAIL stall_stable: valid=%b instr=%h, expected 1 %h",
                             out_valid, out_instr, prev_instr);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_instr = out_instr;
            tick(acc);
            if (acc) sent++;
            if (sent == 8 && sb.size() == 0) break;
        end
        in_valid = 1'b0;
        checks++;
        if (!seen_low || sent != 8 || sb.size() != 0 || enc_count !== 16'd8) begin
            failures++;
            $display("FAIL stream8: ready_fell=%b sent=%0d pending=%0d enc=%0d, expected 1/8/0/8",
                     seen_low, sent, sb.size(), enc_count);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit a;
        out_ready = 1'b1;
        send(2'b00, 32'd11, 7'h13, 5'd1, 3'd0, 5'd1, 5'd0, 7'h00);
        send(2'b00, 32'd12, 7'h13, 5'd2, 3'd0, 5'd1, 5'd0, 7'h00);
        checks++;
        if (out_valid !== 1'b1 || enc_count === 16'd0) begin
            failures++;
            $display("FAIL inflight: valid=%b enc=%0d, expected 1 and nonzero", out_valid, enc_count);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || enc_count !== 16'd0 || err_count !== 16'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: valid=%b enc=%0d errc=%0d ready=%b, expected 0/0/0/1",
                     out_valid, enc_count, err_count, in_ready);
        end
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(2'b00, 32'd5, 7'h13, 5'd4, 3'd0, 5'd3, 5'd0, 7'h00);
        wait_out(ok);
        checks++;
        if (!ok || out_instr !== 32'h0051_8213) begin
            failures++;
            $display("FAIL post_reset: ok=%b instr=%h, expected 00518213", ok, out_instr);
        end
        tick(a);
        checks++;
        if (enc_count !== 16'd1 || sb.size() != 0) begin
            failures++;
            $display("FAIL post_reset_cnt: enc=%0d pending=%0d, expected 1/0", enc_count, sb.size());
        end
    endtask

    task automatic test_count_w4();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(2'b10, 32'd3, 7'h63, 5'd0, 3'd0, 5'(i), 5'd2, 7'h00);
        drain();
        checks++;
        if (enc_count4 !== 4'd1 || err_count4 !== 4'd15) begin
            failures++;
            $display("FAIL cnt_w4: enc=%0d errc=%0d, expected 1/15", enc_count4, err_count4);
        end
        checks++;
        if (enc_count !== 16'd17 || err_count !== 16'd17) begin
            failures++;
            $display("FAIL cnt_w16: enc=%0d errc=%0d, expected 17/17", enc_count, err_count);
        end
    endtask

    task automatic test_random();
        bit acc;
        int sent;
        logic [1:0]  src;
        logic [31:0] imm;
        sent = 0;
        src = 2'b00;
        imm = 32'h0;
        for (int c = 0; c < 600 && sent < 60; c++) begin
            if (!in_valid) begin
                src = 2'($urandom_range(0, 3));
                case (src)
                    2'b00, 2'b01: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                    2'b10:        imm = 32'(int'($urandom_range(0, 4095)) * 2 - 4096);
                    default:      imm = $urandom;
                endcase
                drive(src, imm, 7'($urandom), 5'($urandom), 3'($urandom),
                      5'($urandom), 5'($urandom), 7'($urandom));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        drain();
        checks++;
        if (sent != 60 || sb.size() != 0) begin
            failures++;
            $display("FAIL random: sent=%0d pending=%0d, expected 60/0", sent, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_i_type();
        test_s_b();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_count_w4();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
